// File: rtl/pet_seq_pkg.sv
// Shared types and helpers for the PET CPU cycle-enable sequencer.
package pet_seq_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STOPPED = 2'd1,
    STEP    = 2'd2,
    GRANT   = 2'd3
  } seq_state_e;

  // Master clocks per CPU cycle at speed index spd; never below one.
  function automatic int unsigned div_for_speed(input int unsigned clk_div,
                                                input int unsigned spd);
    int unsigned d;
    d = (spd >= 32) ? 0 : (clk_div >> spd);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/pet_clk_div.sv
// Generic reloadable down-counter: load overrides, enable counts down and
// wraps to the load value at zero, neither holds. tc_o flags a zero count.
module pet_clk_div #(
  parameter int unsigned    W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: explicit load wins, otherwise count down with auto-reload.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? load_val_i : cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= RST_VAL;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pet_cpu_sequencer.sv
// CPU cycle-enable generator: selectable speed, stop/single-step, external
// bus grant for DMA and a free-running video slot enable.
module pet_cpu_sequencer
  import pet_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50,
  parameter int unsigned SPD_W   = 2,
  parameter int unsigned VID_DIV = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SPD_W-1:0] clk_speed,
  input  logic             clk_stop,
  input  logic             step,
  input  logic             ext_req,
  output logic             ext_ack,
  output logic             cpu_en,
  output logic             vid_en,
  output logic             stopped,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned VID_W = (VID_DIV > 1) ? $clog2(VID_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(div_for_speed(CLK_DIV, 0) - 1);
  localparam logic [VID_W-1:0] VID_LOAD = VID_W'(VID_DIV - 1);

  seq_state_e       state_q, state_d;
  logic             cpu_en_q, vid_en_q, ext_ack_q, stopped_q, step_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] reload_val;
  logic             div_tc, vid_tc, div_run, div_load, cpu_pulse, step_rise;

  // Reload value for the CPU divider, from the speed presented this clock.
  always_comb begin
    reload_val = DIV_W'(div_for_speed(CLK_DIV, 32'(clk_speed)) - 1);
  end

  assign step_rise = step && !step_q;

  // Sequencer next state and CPU pulse; ext_req outranks clk_stop outranks step.
  always_comb begin
    state_d   = state_q;
    cpu_pulse = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ext_req) begin
          state_d = GRANT;
        end else begin
          cpu_pulse = div_tc;
          if (clk_stop) state_d = STOPPED;
        end
      end
      STOPPED: begin
        if (ext_req)        state_d = GRANT;
        else if (!clk_stop) state_d = RUN;
        else if (step_rise) state_d = STEP;
      end
      STEP: begin
        if (ext_req) begin
          state_d = GRANT;
        end else if (div_tc) begin
          cpu_pulse = 1'b1;
          state_d   = clk_stop ? STOPPED : RUN;
        end
      end
      GRANT: begin
        if (!ext_req) state_d = clk_stop ? STOPPED : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // The divider is parked at its reload value whenever it is not counting
  // now or will not be counting next, so every resume starts a full cycle.
  always_comb begin
    div_run  = (state_q == RUN) || (state_q == STEP);
    div_load = !div_run || !((state_d == RUN) || (state_d == STEP));
    count_d  = count_q + CNT_W'(cpu_pulse);
  end

  pet_clk_div #(
    .W       (DIV_W),
    .RST_VAL (DIV_RST)
  ) u_cpu_div (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (div_load),
    .load_val_i (reload_val),
    .en_i       (div_run),
    .tc_o       (div_tc)
  );

  pet_clk_div #(
    .W       (VID_W),
    .RST_VAL (VID_LOAD)
  ) u_vid_div (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (1'b0),
    .load_val_i (VID_LOAD),
    .en_i       (1'b1),
    .tc_o       (vid_tc)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      cpu_en_q  <= 1'b0;
      vid_en_q  <= 1'b0;
      ext_ack_q <= 1'b0;
      stopped_q <= 1'b0;
      step_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= cpu_pulse;
      vid_en_q  <= vid_tc;
      ext_ack_q <= (state_d == GRANT);
      stopped_q <= (state_d == STOPPED) || (state_d == STEP);
      step_q    <= step;
      count_q   <= count_d;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign vid_en      = vid_en_q;
  assign ext_ack     = ext_ack_q;
  assign stopped     = stopped_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_pet_cpu_sequencer.sv
// Directed bench for pet_cpu_sequencer with CLK_DIV=8, VID_DIV=2, SPD_W=2.
module tb_pet_cpu_sequencer;

  logic        clk, reset;
  logic [1:0]  clk_speed;
  logic        clk_stop, step, ext_req;
  logic        ext_ack, cpu_en, vid_en, stopped;
  logic [31:0] cycle_count;

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;

  pet_cpu_sequencer #(
    .CLK_DIV (8),
    .SPD_W   (2),
    .VID_DIV (2),
    .CNT_W   (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_speed   (clk_speed),
    .clk_stop    (clk_stop),
    .step        (step),
    .ext_req     (ext_req),
    .ext_ack     (ext_ack),
    .cpu_en      (cpu_en),
    .vid_en      (vid_en),
    .stopped     (stopped),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  // n clocks; cpu_en expected at relative clocks first, first+period, ...
  // vid_en expected on every even clock since reset release.
  task automatic cyc(input int n, input int period, input int first, input string tag);
    for (int i = 1; i <= n; i++) begin
      tick();
      check(tag, 64'(cpu_en), 64'((i >= first) && (((i - first) % period) == 0)));
      check({tag, "_vid"}, 64'(vid_en), 64'((ecnt % 2) == 0));
    end
  endtask

  initial begin
    reset = 1'b1; clk_speed = 2'd0; clk_stop = 1'b0; step = 1'b0; ext_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ecnt = 0;

    // Reset values
    check("rst_cpu_en",  64'(cpu_en),  64'(0));
    check("rst_vid_en",  64'(vid_en),  64'(0));
    check("rst_ext_ack", 64'(ext_ack), 64'(0));
    check("rst_stopped", 64'(stopped), 64'(0));
    check("rst_count",   64'(cycle_count), 64'(0));

    // Speed 0: pulse every 8 clocks, first at clock 8
    cyc(80, 8, 8, "run_spd0");
    check("count_80", 64'(cycle_count), 64'(10));

    // Speed 0 -> 2 mid-cycle: current cycle still 8 long, then every 2
    cyc(3, 1, 4, "pre_spd2");
    clk_speed = 2'd2;
    cyc(9, 2, 5, "spd2");
    check("count_spd2", 64'(cycle_count), 64'(13));

    // Speed 3: divisor 1 after the next reload
    clk_speed = 2'd3;
    cyc(6, 1, 2, "spd3");
    check("count_spd3", 64'(cycle_count), 64'(18));

    // clk_stop rising on a terminal edge: that pulse still issues
    clk_speed = 2'd0;
    clk_stop  = 1'b1;
    cyc(1, 1, 1, "stop_edge");
    check("stop_stopped", 64'(stopped), 64'(1));
    cyc(12, 1, 13, "stopped_idle");
    check("stop_count", 64'(cycle_count), 64'(19));

    // Three single steps, each a full divisor after the sampled edge
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      cyc(10, 100, 9, "step");
      check("step_stopped", 64'(stopped), 64'(1));
      step = 1'b0;
      cyc(2, 1, 3, "step_idle");
    end
    check("step_count", 64'(cycle_count), 64'(22));

    // Release stop: first pulse a full divisor after the sampled edge
    clk_stop = 1'b0;
    cyc(17, 8, 9, "resume");
    check("resume_stopped", 64'(stopped), 64'(0));
    check("resume_count", 64'(cycle_count), 64'(24));

    // ext_req on the terminal edge suppresses that pulse
    cyc(7, 1, 8, "pre_grant");
    ext_req = 1'b1;
    cyc(1, 1, 2, "grant_edge");
    check("grant_ack", 64'(ext_ack), 64'(1));
    cyc(20, 1, 21, "grant_hold");
    check("grant_ack_hold", 64'(ext_ack), 64'(1));
    check("grant_count", 64'(cycle_count), 64'(24));
    ext_req = 1'b0;
    cyc(1, 1, 2, "ungrant_edge");
    check("ungrant_ack", 64'(ext_ack), 64'(0));
    cyc(8, 100, 8, "post_grant");
    check("post_grant_count", 64'(cycle_count), 64'(25));

    // Asynchronous reset while granted with a saturated counter
    ext_req = 1'b1;
    cyc(1, 1, 2, "grant2");
    check("grant2_ack", 64'(ext_ack), 64'(1));
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    check("preset_count", 64'(cycle_count), 64'h0000_0000_FFFF_FFFF);
    #1 reset = 1'b1;
    #1;
    check("async_ack",     64'(ext_ack),     64'(0));
    check("async_count",   64'(cycle_count), 64'(0));
    check("async_stopped", 64'(stopped),     64'(0));
    check("async_cpu_en",  64'(cpu_en),      64'(0));
    ext_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    ecnt = 0;

    // Counter wrap: 0xFFFFFFFF plus one pulse gives 0
    tick();
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    cyc(6, 100, 7, "wrap_wait");
    check("wrap_before", 64'(cycle_count), 64'h0000_0000_FFFF_FFFF);
    cyc(1, 1, 1, "wrap_pulse");
    check("wrap_after", 64'(cycle_count), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
